// File: rtl/data_path_if.sv
// Control-strobe and observation bundle for the single-bus datapath.
// The master side (control unit or bench) drives strobes; the datapath exposes observation values.
interface data_path_if;
    logic [31:0] Mdatain;
    logic [15:0] ALUControl;
    logic [31:0] Rin;
    logic [31:0] Rout;
    logic        IRin;
    logic        MARin;
    logic        RZout;
    logic        RYin;
    logic        RBin;
    logic        PCjump;
    logic        MDRread;
    logic [31:0] bus_value;
    logic [31:0] pc_value;
    logic [31:0] ir_value;
    logic [31:0] mar_value;
    logic [31:0] hi_value;
    logic [31:0] lo_value;

    modport master (
        output Mdatain, ALUControl, Rin, Rout, IRin, MARin, RZout, RYin, RBin, PCjump, MDRread,
        input  bus_value, pc_value, ir_value, mar_value, hi_value, lo_value
    );
    modport slave (
        input  Mdatain, ALUControl, Rin, Rout, IRin, MARin, RZout, RYin, RBin, PCjump, MDRread,
        output bus_value, pc_value, ir_value, mar_value, hi_value, lo_value
    );
endinterface

// File: rtl/data_path.sv
// Single-bus 32-bit datapath: register file, special registers, 16-op ALU into a 64-bit Z.
// Define DATAPATH_MULDIV_EN to build the signed multiplier/divider for ops 14/15.
module data_path #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] PC_INC   = 32'd1
) (
    input logic     clock,
    input logic     clear,
    data_path_if.slave dp
);
    logic [15:0][31:0] gpr;
    logic [31:0] hi, lo, pc, ir, mar, mdr, y, rb;
    logic [63:0] z;
    logic [31:0] bus, a, b;
    logic [4:0]  sh;
    logic [31:0] alu_hi, alu_lo;
    logic [22:0][31:0] src;
    logic [22:0] sel;

    always_comb begin
        for (int i = 0; i < 16; i++) src[i] = gpr[i];
        src[16] = hi;
        src[17] = lo;
        src[18] = z[63:32];
        src[19] = z[31:0];
        src[20] = pc;
        src[21] = mdr;
        src[22] = {{13{ir[18]}}, ir[18:0]};
    end

    assign sel = {dp.Rout[22:20], dp.Rout[19] | dp.RZout, dp.Rout[18:0]};

    // Scan from the top so the lowest-index selected source ends up on the bus
    always_comb begin
        bus = '0;
        for (int i = 22; i >= 0; i--)
            if (sel[i]) bus = src[i];
    end

    assign a  = y;
    assign b  = bus;
    assign sh = b[4:0];

`ifdef DATAPATH_MULDIV_EN
    logic signed [63:0] prod;
    logic signed [31:0] quo, rem;
    assign prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    // Zero divisor and the lone overflowing quotient get fixed results
    always_comb begin
        if (b == 32'h0) begin
            quo = -32'sd1;
            rem = $signed(a);
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            quo = 32'sh8000_0000;
            rem = 32'sd0;
        end else begin
            quo = $signed(a) / $signed(b);
            rem = $signed(a) % $signed(b);
        end
    end
`endif

    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        case (dp.ALUControl[3:0])
            4'd0:  alu_lo = b + PC_INC;
            4'd1:  alu_lo = a + b;
            4'd2:  alu_lo = a - b;
            4'd3:  alu_lo = a & b;
            4'd4:  alu_lo = a | b;
            4'd5:  alu_lo = a ^ b;
            4'd6:  alu_lo = a >> sh;
            4'd7:  alu_lo = $unsigned($signed(a) >>> sh);
            4'd8:  alu_lo = a << sh;
            4'd9:  alu_lo = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
            4'd10: alu_lo = (a << sh) | (a >> (6'd32 - {1'b0, sh}));
            4'd11: alu_lo = -b;
            4'd12: alu_lo = ~b;
            4'd13: alu_lo = b;
`ifdef DATAPATH_MULDIV_EN
            4'd14: {alu_hi, alu_lo} = prod;
            4'd15: begin
                alu_hi = rem;
                alu_lo = quo;
            end
`endif
            default: begin
                alu_hi = '0;
                alu_lo = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            gpr <= '0;
            hi  <= '0;
            lo  <= '0;
            pc  <= RESET_PC;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            y   <= '0;
            z   <= '0;
            rb  <= '0;
        end else begin
            for (int i = 0; i < 16; i++)
                if (dp.Rin[i]) gpr[i] <= bus;
            if (dp.Rin[16]) hi <= bus;
            if (dp.Rin[17]) lo <= bus;
            if (dp.Rin[18]) z[63:32] <= alu_hi;
            if (dp.Rin[19]) z[31:0]  <= alu_lo;
            if (dp.PCjump)       pc <= rb;
            else if (dp.Rin[20]) pc <= bus;
            if (dp.Rin[21]) mdr <= dp.MDRread ? dp.Mdatain : bus;
            if (dp.IRin)  ir  <= bus;
            if (dp.MARin) mar <= bus;
            if (dp.RYin)  y   <= bus;
            if (dp.RBin)  rb  <= bus;
        end
    end

    assign dp.bus_value = bus;
    assign dp.pc_value  = pc;
    assign dp.ir_value  = ir;
    assign dp.mar_value = mar;
    assign dp.hi_value  = hi;
    assign dp.lo_value  = lo;

    logic unused_bits;
    assign unused_bits = ^{dp.ALUControl[15:4], dp.Rin[31:22], dp.Rout[31:23]};
endmodule

// File: tb/tb_data_path.sv
// Directed vector bench for data_path: one table row per clock cycle, plus reset sequences.
module tb_data_path;
`ifdef DATAPATH_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam logic [6:0] C_IR = 7'h01, C_MAR = 7'h02, C_RZ = 7'h04, C_RY = 7'h08,
                           C_RB = 7'h10, C_JMP = 7'h20, C_RD = 7'h40;
    localparam int F_NONE = 0, F_BUS = 1, F_PC = 2, F_IR = 3, F_MAR = 4, F_HI = 5, F_LO = 6;

    typedef struct {
        logic [31:0] rin;
        logic [31:0] rout;
        logic [15:0] op;
        logic [31:0] mdat;
        logic [6:0]  ctl;
        int          fld;
        logic [31:0] exp;
    } vec_t;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];

    data_path_if dpi();
    data_path dut (.clock(clock), .clear(clear), .dp(dpi));

    always #5 clock = ~clock;

    function automatic logic [31:0] bt(input int i);
        return 32'd1 << i;
    endfunction

    function automatic logic [31:0] md(input logic [31:0] v);
        return MD ? v : 32'h0;
    endfunction

    task automatic add(input logic [31:0] rin, input logic [31:0] rout, input logic [15:0] op,
                       input logic [31:0] mdat, input logic [6:0] ctl, input int fld,
                       input logic [31:0] exp);
        vec_t v;
        v.rin = rin; v.rout = rout; v.op = op; v.mdat = mdat;
        v.ctl = ctl; v.fld = fld; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int fld);
        case (fld)
            F_BUS:   return dpi.bus_value;
            F_PC:    return dpi.pc_value;
            F_IR:    return dpi.ir_value;
            F_MAR:   return dpi.mar_value;
            F_HI:    return dpi.hi_value;
            default: return dpi.lo_value;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        dpi.Rin = v.rin; dpi.Rout = v.rout; dpi.ALUControl = v.op; dpi.Mdatain = v.mdat;
        dpi.IRin = v.ctl[0]; dpi.MARin = v.ctl[1]; dpi.RZout = v.ctl[2]; dpi.RYin = v.ctl[3];
        dpi.RBin = v.ctl[4]; dpi.PCjump = v.ctl[5]; dpi.MDRread = v.ctl[6];
    endtask

    logic [31:0] alu_exp [14];

    initial begin
        vec_t idle;
        idle = '{rin: 0, rout: 0, op: 16'd13, mdat: 0, ctl: 0, fld: F_NONE, exp: 0};
        alu_exp = '{32'h00000027, 32'hF0000029, 32'hEFFFFFDD, 32'h00000002, 32'hF0000027,
                    32'hF0000025, 32'h03C00000, 32'hFFC00000, 32'h000000C0, 32'h0FC00000,
                    32'h000000FC, 32'hFFFFFFDA, 32'hFFFFFFD9, 32'h00000026};

        // PC increment through Z, instruction fetch through MDR
        add(bt(19), bt(20), 16'd0, 0, C_MAR, F_MAR, 32'h0);
        add(bt(20), bt(19), 16'd13, 0, 0, F_PC, 32'h1);
        add(bt(21), 0, 16'd13, 32'h112B0000, C_RD, F_BUS, 32'h0);
        add(0, bt(21), 16'd13, 0, C_IR, F_IR, 32'h112B0000);
        add(0, bt(22), 16'd13, 0, 0, F_BUS, 32'h00030000);
        add(0, bt(21) | bt(22), 16'd13, 0, 0, F_BUS, 32'h112B0000);
        add(bt(21), 0, 16'd13, 32'h00040000, C_RD, F_NONE, 0);
        add(0, bt(21), 16'd13, 0, C_IR, F_IR, 32'h00040000);
        add(0, bt(22), 16'd13, 0, 0, F_BUS, 32'hFFFC0000);
        add(0, bt(23) | bt(31), 16'd13, 0, 0, F_BUS, 32'h0);
        add(bt(16) | bt(17) | bt(25), bt(21), 16'd13, 0, 0, F_HI, 32'h00040000);
        add(0, 0, 16'd13, 0, 0, F_LO, 32'h00040000);

        // ALU sweep: Y = F0000003, bus = MDR = 26
        add(bt(21), 0, 16'd13, 32'hF0000003, C_RD, F_NONE, 0);
        add(0, bt(21), 16'd13, 0, C_RY, F_NONE, 0);
        add(bt(21), 0, 16'd13, 32'h00000026, C_RD, F_NONE, 0);
        for (int k = 0; k < 14; k++) begin
            add(bt(19), bt(21), (k == 1) ? 16'hA001 : 16'(k), 0, 0, F_BUS, 32'h26);
            if (k % 2 == 0) add(bt(17), bt(19), 16'd13, 0, 0, F_LO, alu_exp[k]);
            else            add(bt(17), 0, 16'd13, 0, C_RZ, F_LO, alu_exp[k]);
        end
        add(bt(16), bt(18), 16'd13, 0, 0, F_HI, 32'h0);

        // R0 beats MDR on the bus
        add(bt(0), bt(21), 16'd13, 0, 0, F_NONE, 0);
        add(bt(21), 0, 16'd13, 32'h55, C_RD, F_NONE, 0);
        add(0, bt(0) | bt(21), 16'd13, 0, 0, F_BUS, 32'h26);

        // 19 / 5 and 19 / 0
        add(bt(21), 0, 16'd13, 32'd19, C_RD, F_NONE, 0);
        add(bt(3), bt(21), 16'd13, 0, 0, F_NONE, 0);
        add(bt(21), 0, 16'd13, 32'd5, C_RD, F_NONE, 0);
        add(bt(1), bt(21), 16'd13, 0, 0, F_NONE, 0);
        add(0, bt(3), 16'd13, 0, C_RY, F_NONE, 0);
        add(bt(18) | bt(19), bt(1), 16'd15, 0, 0, F_NONE, 0);
        add(bt(17), bt(19), 16'd13, 0, 0, F_LO, md(32'd3));
        add(bt(16), bt(18), 16'd13, 0, 0, F_HI, md(32'd4));
        add(bt(21), 0, 16'd13, 32'd0, C_RD, F_NONE, 0);
        add(bt(1), bt(21), 16'd13, 0, 0, F_NONE, 0);
        add(bt(18) | bt(19), bt(1), 16'd15, 0, 0, F_NONE, 0);
        add(bt(17), bt(19), 16'd13, 0, 0, F_LO, md(32'hFFFFFFFF));
        add(bt(16), bt(18), 16'd13, 0, 0, F_HI, md(32'd19));

        // 0x10000 * 0x10000
        add(bt(21), 0, 16'd13, 32'h00010000, C_RD, F_NONE, 0);
        add(0, bt(21), 16'd13, 0, C_RY, F_NONE, 0);
        add(bt(18) | bt(19), bt(21), 16'd14, 0, 0, F_NONE, 0);
        add(bt(17), bt(19), 16'd13, 0, 0, F_LO, 32'h0);
        add(bt(16), bt(18), 16'd13, 0, 0, F_HI, md(32'h1));

        // -7 / 2
        add(bt(21), 0, 16'd13, 32'hFFFFFFF9, C_RD, F_NONE, 0);
        add(0, bt(21), 16'd13, 0, C_RY, F_NONE, 0);
        add(bt(21), 0, 16'd13, 32'd2, C_RD, F_NONE, 0);
        add(bt(18) | bt(19), bt(21), 16'd15, 0, 0, F_NONE, 0);
        add(bt(17), bt(19), 16'd13, 0, 0, F_LO, md(32'hFFFFFFFD));
        add(bt(16), bt(18), 16'd13, 0, 0, F_HI, md(32'hFFFFFFFF));

        // 0x80000000 / -1
        add(bt(21), 0, 16'd13, 32'h80000000, C_RD, F_NONE, 0);
        add(0, bt(21), 16'd13, 0, C_RY, F_NONE, 0);
        add(bt(21), 0, 16'd13, 32'hFFFFFFFF, C_RD, F_NONE, 0);
        add(bt(18) | bt(19), bt(21), 16'd15, 0, 0, F_NONE, 0);
        add(bt(17), bt(19), 16'd13, 0, 0, F_LO, md(32'h80000000));
        add(bt(16), bt(18), 16'd13, 0, 0, F_HI, 32'h0);

        // Branch target and PCjump priority over Rin[20]
        add(bt(21), 0, 16'd13, 32'h40, C_RD, F_NONE, 0);
        add(0, bt(21), 16'd13, 0, C_RB, F_NONE, 0);
        add(bt(21), 0, 16'd13, 32'd5, C_RD, F_NONE, 0);
        add(bt(19), bt(21), 16'd13, 0, 0, F_NONE, 0);
        add(bt(20), bt(19), 16'd13, 0, 0, F_PC, 32'd5);
        add(bt(20), bt(19), 16'd13, 0, C_JMP, F_PC, 32'h40);

        // Reset state
        drive(idle);
        #12;
        chk("rst_pc", dpi.pc_value, 32'h0);
        chk("rst_ir", dpi.ir_value, 32'h0);
        chk("rst_mar", dpi.mar_value, 32'h0);
        chk("rst_hi", dpi.hi_value, 32'h0);
        chk("rst_lo", dpi.lo_value, 32'h0);
        chk("rst_bus", dpi.bus_value, 32'h0);
        @(negedge clock);
        clear = 1'b1;

        foreach (vq[i]) begin
            @(negedge clock);
            drive(vq[i]);
            #1;
            if (vq[i].fld == F_BUS) chk($sformatf("vec%0d_bus", i), dpi.bus_value, vq[i].exp);
            @(posedge clock);
            #1;
            if (vq[i].fld > F_BUS) chk($sformatf("vec%0d", i), obs(vq[i].fld), vq[i].exp);
        end

        // Reset asserted mid-transfer clears everything at once and blocks the load
        @(negedge clock);
        drive(idle);
        dpi.Rin = bt(16) | bt(17) | bt(20);
        dpi.Rout = bt(21);
        dpi.IRin = 1'b1;
        dpi.MARin = 1'b1;
        #1;
        chk("pre_clr_bus", dpi.bus_value, 32'd5);
        #1 clear = 1'b0;
        #1;
        chk("clr_pc", dpi.pc_value, 32'h0);
        chk("clr_ir", dpi.ir_value, 32'h0);
        chk("clr_mar", dpi.mar_value, 32'h0);
        chk("clr_hi", dpi.hi_value, 32'h0);
        chk("clr_lo", dpi.lo_value, 32'h0);
        chk("clr_bus_mdr", dpi.bus_value, 32'h0);
        @(posedge clock);
        #1;
        chk("clr_hold_lo", dpi.lo_value, 32'h0);
        dpi.Rout = 32'h0;
        #1;
        chk("clr_bus_idle", dpi.bus_value, 32'h0);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Single-bus 32-bit CPU datapath for the phase-1 processor.
- Holds R0–R15, HI, LO, PC, IR, MAR, MDR, Y, a 64-bit Z and a branch-target register RB, plus a 16-operation ALU.
- The external control unit or bench drives one-hot register-out and register-in strobes and selects the ALU operation.
- All register loads occur on rising clock edges.

Parameters:
- RESET_PC, 32'h0, value PC takes on reset.
- PC_INC, 1, increment applied by ALU op 0 (INCPC).

Ports:
- clock  in  1  system clock; all loads on rising edge.
- clear  in  1  reset; asynchronous, active-low; clears every register.
- Mdatain  in  32  memory read data; MDR source when MDRread=1.
- ALUControl  in  16  ALU operation code; bits [3:0] used, [15:4] ignored.
- Rin  in  32  register load strobes: [15:0] R0–R15, 16 HI, 17 LO, 18 ZHigh, 19 ZLow, 20 PC, 21 MDR, [31:22] ignored.
- Rout  in  32  bus drive selects: [15:0] R0–R15, 16 HI, 17 LO, 18 ZHigh, 19 ZLow, 20 PC, 21 MDR, 22 sign-extended IR[18:0], [31:23] ignored.
- IRin  in  1  IR <= bus.
- MARin  in  1  MAR <= bus.
- RZout  in  1  drives ZLow onto the bus; ORed with Rout[19].
- RYin  in  1  Y <= bus.
- RBin  in  1  RB <= bus (branch target).
- PCjump  in  1  PC <= RB; overrides Rin[20].
- MDRread  in  1  MDR input mux: 1 = Mdatain, 0 = bus.
- bus_value  out  32  current bus value (observation).
- pc_value, ir_value, mar_value, hi_value, lo_value  out  32 each  register observation.

Behaviour:
- Reset: clear=0 immediately sets PC=RESET_PC; all other registers (R0–R15, HI, LO, IR, MAR, MDR, Y, Z, RB) = 0. Reset asserted mid-operation aborts it; no load occurs while clear=0.
- Bus: combinational priority mux. The lowest-index asserted Rout bit wins. With no source selected, the bus is 0.
- Register load: on posedge, each register with its strobe high latches the bus. Several destinations may load in the same cycle.
- MDR: if Rin[21]=1 at posedge, MDR <= MDRread ? Mdatain : bus.
- ALU operands and result:
  - A = Y, B = bus.
  - Result is combinational 64 bits {hi,lo}; hi=0 except for MUL and DIV.
  - Rin[18] loads ZHigh <= hi; Rin[19] loads ZLow <= lo.
- ALU op codes:
  - 0 INCPC: B + PC_INC.
  - 1 ADD, 2 SUB (A−B), 3 AND, 4 OR, 5 XOR.
  - 6 SHR (logical), 7 SHRA, 8 SHL, 9 ROR, 10 ROL; shift/rotate amount = B[4:0].
  - 11 NEG (−B), 12 NOT (~B), 13 pass B.
  - 14 MUL: signed A×B, 64-bit product.
  - 15 DIV: signed A÷B; lo = quotient truncated toward zero, hi = remainder with the sign of A.
- DIV boundaries:
  - B=0: lo=32'hFFFFFFFF, hi=A.
  - A=32'h80000000, B=−1: lo=32'h80000000, hi=0.
- Arithmetic wraps modulo 2^32; no flags.
- PC: PCjump has priority over Rin[20]. Both conditions apply at posedge.
- Latency: register-to-register transfer in 1 cycle. ALU result reaches Z at the same edge the operands are presented.

Optional Feature:
- DATAPATH_MULDIV_EN
  - Defined: ops 14/15 implemented as specified.
  - Undefined: ops 14/15 produce hi=lo=0; no multiplier or divider is synthesized.

Test Plan:
- Reset, then Rout[20]+MARin+Rin[19] with ALUControl=0 -> MAR=0; next cycle Rout[19]+Rin[20] -> PC=1.
- Mdatain=32'h112B0000, MDRread=1, Rin[21] -> MDR=32'h112B0000; then Rout[21]+IRin -> IR=32'h112B0000.
- Load R3=19 and R1=5 via MDR; Y<=R3; R1out with ALUControl=15 and Rin[18],[19]; move Z to LO/HI -> LO=3, HI=4. Repeat with R1=0 -> LO=32'hFFFFFFFF, HI=19.
- Y=32'h00010000, bus=32'h00010000, op 14 -> ZHigh=1, ZLow=0. Also Y=−7, bus=2, op 15 -> lo=−3, hi=−1.
- RBin with bus=32'h40, then PCjump together with Rin[20] and ZLow=5 -> PC=32'h40.
- Assert clear=0 between posedges during a transfer -> all registers 0 immediately. With Rout=0 -> bus_value=0.
